// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between the CPU MEM stage (port 0)
// and the debug/loader port (port 1). It sequences each multi-cycle access and acks the owner.
module dmem_arbiter #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    output logic        gnt0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        gnt1,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    localparam logic [32:0] AddrLimit = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CntInit   = 4'(LATENCY - 1);

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic [3:0]  cnt_q;
    logic        we_q;

    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    // On a tie the port that was not served last wins.
    always_comb begin
        sel       = (req0 && req1) ? ~last_q : req1;
        sel_we    = sel ? we1 : we0;
        sel_addr  = sel ? addr1 : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        sel_bad   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= AddrLimit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            cnt_q          <= 4'd0;
            we_q           <= 1'b0;
            ack0           <= 1'b0;
            err0           <= 1'b0;
            rdata0         <= 32'd0;
            gnt0           <= 1'b0;
            ack1           <= 1'b0;
            err1           <= 1'b0;
            rdata1         <= 32'd0;
            gnt1           <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q <= sel;
                        last_q  <= sel;
                        we_q    <= sel_we;
                        gnt0    <= ~sel;
                        gnt1    <= sel;
                        if (sel_bad) begin
                            // Rejected requests never reach the memory.
                            state_q <= StDone;
                            ack0    <= ~sel;
                            err0    <= ~sel;
                            ack1    <= sel;
                            err1    <= sel;
                        end else begin
                            state_q        <= StAccess;
                            cnt_q          <= CntInit;
                            mem_address    <= sel_addr;
                            mem_write_data <= sel_wdata;
                            mem_read       <= ~sel_we;
                            mem_write      <= sel_we;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q        <= StDone;
                        mem_address    <= 32'd0;
                        mem_write_data <= 32'd0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        ack0           <= ~owner_q;
                        ack1           <= owner_q;
                        if (!we_q) begin
                            if (owner_q) rdata1 <= mem_read_data;
                            else         rdata0 <= mem_read_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single transactions plus hand-written sequences
// for contention, reset during a write, and a LATENCY=1 build.
module tb_dmem_arbiter;

    localparam int unsigned Lat = 2;

    logic        clk;
    logic        reset;
    logic        req0, we0, ack0, err0, gnt0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, err1, gnt1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    logic        l1_req0, l1_we0, l1_ack0, l1_err0, l1_gnt0;
    logic [31:0] l1_addr0, l1_wdata0, l1_rdata0;
    logic        l1_req1, l1_we1, l1_ack1, l1_err1, l1_gnt1;
    logic [31:0] l1_addr1, l1_wdata1, l1_rdata1;
    logic [31:0] l1_mem_address, l1_mem_write_data, l1_mem_read_data;
    logic        l1_mem_read, l1_mem_write;

    logic [31:0] mem [256];
    logic [31:0] last_rd [2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [12];

    dmem_arbiter #(.LATENCY(Lat), .DEPTH_WORDS(256)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0), .gnt0(gnt0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1), .gnt1(gnt1),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    dmem_arbiter #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req0(l1_req0), .we0(l1_we0), .addr0(l1_addr0), .wdata0(l1_wdata0),
        .ack0(l1_ack0), .err0(l1_err0), .rdata0(l1_rdata0), .gnt0(l1_gnt0),
        .req1(l1_req1), .we1(l1_we1), .addr1(l1_addr1), .wdata1(l1_wdata1),
        .ack1(l1_ack1), .err1(l1_err1), .rdata1(l1_rdata1), .gnt1(l1_gnt1),
        .mem_address(l1_mem_address), .mem_write_data(l1_mem_write_data),
        .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_read_data(l1_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data    = mem[mem_address[9:2]];
    assign l1_mem_read_data = mem[l1_mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        l1_req0 = 1'b0;
        l1_req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
    endtask

    // One transaction from an idle arbiter; req drops in the ack cycle so it is not re-taken.
    task automatic txn(input int idx, input vec_t v);
        int   cyc = 0;
        int   rd = 0;
        int   wr = 0;
        int   gc = 0;
        int   bad = 0;
        logic got = 1'b0;
        logic ev = 1'b0;
        int   exp_lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_lat = v.err ? 1 : Lat + 1;
        @(negedge clk);
        if (v.port == 0) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_read) rd++;
            if (mem_write) wr++;
            if ((mem_read || mem_write) && mem_address != v.addr) bad++;
            if (mem_write && mem_write_data != v.wdata) bad++;
            if (gnt0 && gnt1) bad++;
            if ((v.port == 0) ? gnt0 : gnt1) gc++;
            if ((v.port == 0) ? ack1 : ack0) bad++;
            if ((v.port == 0) ? ack0 : ack1) begin
                got = 1'b1;
                ev  = (v.port == 0) ? err0 : err1;
                if (mem_address != 32'd0 || mem_read || mem_write) bad++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!v.we && !v.err) last_rd[v.port] = v.rdata;
        chk({tag, "_ack"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_err"}, 32'(ev), 32'(v.err));
        chk({tag, "_rdcyc"}, rd, (!v.we && !v.err) ? Lat : 0);
        chk({tag, "_wrcyc"}, wr, (v.we && !v.err) ? Lat : 0);
        chk({tag, "_gnt"}, gc, exp_lat);
        chk({tag, "_bus"}, bad, 0);
        chk({tag, "_rdata"}, (v.port == 0) ? rdata0 : rdata1, last_rd[v.port]);
    endtask

    initial begin
        int   first, prev, alt_bad, nacks, both, cyc, rd;
        logic got;

        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        l1_req0 = 1'b0; l1_we0 = 1'b0; l1_addr0 = '0; l1_wdata0 = '0;
        l1_req1 = 1'b0; l1_we1 = 1'b0; l1_addr1 = '0; l1_wdata1 = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFEF00D;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'h22222222;

        //           port we    addr      wdata         err   rdata
        vecs[0]  = '{0, 1'b0, 32'd4,    32'd0,        1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1, 1'b1, 32'd8,    32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[2]  = '{1, 1'b0, 32'd8,    32'd0,        1'b0, 32'hFFFFFFFF};
        vecs[3]  = '{0, 1'b1, 32'd12,   32'h12345678, 1'b0, 32'd0};
        vecs[4]  = '{1, 1'b0, 32'd12,   32'd0,        1'b0, 32'h12345678};
        vecs[5]  = '{0, 1'b0, 32'd6,    32'd0,        1'b1, 32'd0};
        vecs[6]  = '{1, 1'b0, 32'd1024, 32'd0,        1'b1, 32'd0};
        vecs[7]  = '{1, 1'b1, 32'd1020, 32'hA5A5A5A5, 1'b0, 32'd0};
        vecs[8]  = '{0, 1'b0, 32'd1020, 32'd0,        1'b0, 32'hA5A5A5A5};
        vecs[9]  = '{0, 1'b1, 32'd1021, 32'h0BADF00D, 1'b1, 32'd0};
        vecs[10] = '{0, 1'b0, 32'd8,    32'd0,        1'b0, 32'hFFFFFFFF};
        vecs[11] = '{1, 1'b0, 32'd4,    32'd0,        1'b0, 32'hDEADBEEF};

        do_reset();
        chk("rst_ctrl", 32'({ack0, ack1, err0, err1, gnt0, gnt1, mem_read, mem_write}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_maddr", mem_address, 32'd0);
        chk("rst_mwdata", mem_write_data, 32'd0);

        // Both ports request continuously straight out of reset.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
        first = -1; prev = -1; alt_bad = 0; nacks = 0; both = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both++;
            if (ack0 && ack1) both++;
            if (ack0 || ack1) begin
                if (first < 0) first = ack1 ? 1 : 0;
                if ((ack1 ? 1 : 0) == prev) alt_bad++;
                prev = ack1 ? 1 : 0;
                nacks++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("cont_first", first, 0);
        chk("cont_alternate", alt_bad, 0);
        chk("cont_count", nacks, 10);
        chk("cont_overlap", both, 0);
        chk("cont_rdata0", rdata0, 32'hDEADBEEF);
        chk("cont_rdata1", rdata1, 32'h22222222);

        do_reset();
        for (int i = 0; i < 12; i++) txn(i, vecs[i]);

        // Reset lands in the second ACCESS cycle of a write.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'h11111111;
        @(negedge clk);
        chk("rmw_access1", 32'(mem_write), 32'd1);
        @(negedge clk);
        chk("rmw_access2", 32'(mem_write), 32'd1);
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        chk("rmw_after", 32'({mem_write, mem_read, gnt0, gnt1, ack0, ack1}), 32'd0);
        chk("rmw_maddr", mem_address, 32'd0);
        reset      = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        txn(12, vecs[0]);

        // LATENCY=1 build: read of address 0.
        do_reset();
        @(negedge clk);
        l1_req0 = 1'b1; l1_we0 = 1'b0; l1_addr0 = 32'd0;
        cyc = 0; rd = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (l1_mem_read) rd++;
            if (l1_ack0) got = 1'b1;
        end
        l1_req0 = 1'b0;
        chk("l1_ack", 32'(got), 32'd1);
        chk("l1_lat", cyc, 2);
        chk("l1_rdcyc", rd, 1);
        chk("l1_err", 32'(l1_err0), 32'd0);
        chk("l1_rdata", l1_rdata0, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
